// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rns_pkg
// Brief    : Default moduli set, CRT weights and FSM/mode types shared by the
//            sequential int<->RNS convertor.
// Revision : 1.0 - initial release
// ============================================================================
package rns_pkg;

    localparam int RNS_N_MOD = 4;
    localparam int RNS_RES_W = 8;
    localparam int RNS_INT_W = 32;

    localparam int CRT_W_WIDTH  = RNS_N_MOD * RNS_INT_W;
    localparam int M_PROD_WIDTH = RNS_INT_W;

    // Pairwise coprime moduli 251, 253, 254, 255; channel 0 in the LSBs
    localparam logic [RNS_N_MOD*RNS_RES_W-1:0] MODULI =
        {8'd255, 8'd254, 8'd253, 8'd251};

    // Mi * inv(Mi mod mi) mod M for each channel, channel 0 in the LSBs
    localparam logic [CRT_W_WIDTH-1:0] CRT_W =
        {32'd3596936926, 32'd1376427525, 32'd1024208010, 32'd2228606160};

    localparam logic [M_PROD_WIDTH-1:0] M_PROD           = 32'd4113089310;
    localparam logic [RNS_INT_W-1:0]    INT_RNS_DELTA    = 32'd181877986;
    localparam logic [RNS_INT_W-1:0]    RNS_MIDDLE_POINT = 32'd2056544655;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } rns_cvt_state_t;

    typedef enum logic {
        MODE_INT2RNS = 1'b0,
        MODE_RNS2INT = 1'b1
    } rns_cvt_mode_t;

endpackage
`default_nettype wire

// File: rtl/rns_mod_mac.sv
`default_nettype none
// ============================================================================
// Module   : rns_mod_mac
// Brief    : Combinational (a + w*r) % m step; with w=r=0 it reduces a % m.
// Revision : 1.0 - initial release
// ============================================================================
module rns_mod_mac #(
    parameter int INT_W = 32,
    parameter int RES_W = 8
) (
    input  logic [INT_W-1:0] a,
    input  logic [INT_W-1:0] w,
    input  logic [RES_W-1:0] r,
    input  logic [INT_W-1:0] m,
    output logic [INT_W-1:0] y
);

    // Full-width product and sum so nothing is lost before the reduction
    localparam int PROD_W = INT_W + RES_W + 1;

    assign y = INT_W'(((PROD_W'(w) * PROD_W'(r)) + PROD_W'(a)) % PROD_W'(m));

endmodule
`default_nettype wire

// File: rtl/rns_convertor_seq.sv
`default_nettype none
// ============================================================================
// Module   : rns_convertor_seq
// Brief    : Sequential int<->RNS convertor, one residue channel per cycle,
//            direction selected per transaction. Optional residue/width range
//            check enabled by defining RNS_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rns_convertor_seq #(
    parameter int                      N_MOD  = rns_pkg::RNS_N_MOD,
    parameter int                      RES_W  = rns_pkg::RNS_RES_W,
    parameter int                      INT_W  = rns_pkg::RNS_INT_W,
    parameter logic [N_MOD*RES_W-1:0]  MODULI = rns_pkg::MODULI,
    parameter logic [N_MOD*INT_W-1:0]  CRT_W  = rns_pkg::CRT_W,
    parameter logic [INT_W-1:0]        M_PROD = rns_pkg::M_PROD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [N_MOD*RES_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic [N_MOD*RES_W-1:0] out_data,
    output logic                   out_err
);

    import rns_pkg::*;

    // The residue vector is assumed at least as wide as the integer
    localparam int DATA_W = N_MOD * RES_W;
    localparam int CHAN_W = $clog2(N_MOD);

    localparam logic [INT_W-1:0]  c_delta = INT_W'(0) - M_PROD;
    localparam logic [INT_W-1:0]  c_mid   = {1'b0, M_PROD[INT_W-1:1]} + INT_W'(M_PROD[0]);
    localparam logic [CHAN_W-1:0] c_last  = CHAN_W'(N_MOD - 1);

    rns_cvt_state_t     r_state;
    rns_cvt_state_t     w_next;
    logic               r_mode;
    logic [CHAN_W-1:0]  r_chan;
    logic [DATA_W-1:0]  r_src;
    logic [INT_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_out;

    logic [INT_W-1:0]   w_in_int;
    logic [INT_W-1:0]   w_x;
    logic [RES_W-1:0]   w_res;
    logic [RES_W-1:0]   w_mod;
    logic [INT_W-1:0]   w_wgt;
    logic [INT_W-1:0]   w_mac_a;
    logic [INT_W-1:0]   w_mac_w;
    logic [RES_W-1:0]   w_mac_r;
    logic [INT_W-1:0]   w_mac_m;
    logic [INT_W-1:0]   w_mac;
    logic [INT_W-1:0]   w_final;

    // Negative integers are folded into [M/2, M) before reduction
    assign w_in_int = in_data[INT_W-1:0];
    assign w_x      = w_in_int[INT_W-1] ? (w_in_int - c_delta) : w_in_int;

    assign w_res = r_src[r_chan*RES_W +: RES_W];
    assign w_mod = MODULI[r_chan*RES_W +: RES_W];
    assign w_wgt = CRT_W[r_chan*INT_W +: INT_W];

    always_comb begin
        w_mac_a = r_src[INT_W-1:0];
        w_mac_w = '0;
        w_mac_r = '0;
        w_mac_m = INT_W'(w_mod);
        if (r_mode) begin
            w_mac_a = r_acc;
            w_mac_w = w_wgt;
            w_mac_r = w_res;
            w_mac_m = M_PROD;
        end
    end

    rns_mod_mac #(
        .INT_W (INT_W),
        .RES_W (RES_W)
    ) u_mac (
        .a (w_mac_a),
        .w (w_mac_w),
        .r (w_mac_r),
        .m (w_mac_m),
        .y (w_mac)
    );

    // Upper half of the range maps back to negative two's complement
    assign w_final = (w_mac >= c_mid) ? (w_mac + c_delta) : w_mac;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)         w_next = CALC;
            CALC:    if (r_chan == c_last) w_next = DONE;
            DONE:    if (out_ready)        w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_chan <= '0;
            r_src  <= '0;
            r_acc  <= '0;
            r_out  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mode <= in_mode;
                        r_src  <= in_mode ? in_data : DATA_W'(w_x);
                        r_chan <= '0;
                        r_acc  <= '0;
                        r_out  <= '0;
                    end
                end
                CALC: begin
                    r_chan <= r_chan + CHAN_W'(1);
                    if (r_mode) begin
                        r_acc <= w_mac;
                        if (r_chan == c_last) begin
                            r_out <= DATA_W'(w_final);
                        end
                    end else begin
                        r_out[r_chan*RES_W +: RES_W] <= w_mac[RES_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out_mode  = r_mode;
    assign out_data  = r_out;

`ifdef RNS_RANGE_CHECK_EN
    logic [N_MOD-1:0] w_over;
    logic             w_hi;
    logic             w_err_in;
    logic             r_err;

    for (genvar gi = 0; gi < N_MOD; gi++) begin : g_chk
        assign w_over[gi] = in_data[gi*RES_W +: RES_W] >= MODULI[gi*RES_W +: RES_W];
    end

    if (DATA_W > INT_W) begin : g_hi
        assign w_hi = |in_data[DATA_W-1:INT_W];
    end else begin : g_no_hi
        assign w_hi = 1'b0;
    end

    assign w_err_in = in_mode ? (|w_over) : w_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && in_valid) begin
            r_err <= w_err_in;
        end
    end

    assign out_err = r_err && (r_state == DONE);
`else
    assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rns_convertor_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rns_convertor_seq
// Brief    : Directed self-checking bench for rns_convertor_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rns_convertor_seq;

    localparam longint      c_m    = 64'sd4113089310;
    localparam longint      c_half = 64'sd2056544655;
    localparam int unsigned c_mods [4] = '{251, 253, 254, 255};
    localparam int          c_lat  = 5;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [31:0] out_data;
    logic        out_err;

    int n_assert;
    int n_fail;

    rns_convertor_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input longint x);
        longint      xm;
        logic [31:0] r;
        xm = x % c_m;
        if (xm < 0) xm = xm + c_m;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(xm % longint'(c_mods[i]));
        return r;
    endfunction

    // Called at a negedge in IDLE; returns at the first negedge with out_valid
    task automatic do_req(input logic mode, input logic [31:0] data,
                          output logic [31:0] res, output logic err, output int lat);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk1("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk1("done_valid", out_valid, 1'b1);
        res = out_data;
        err = out_err;
    endtask

    logic [31:0] res;
    logic [31:0] fwd;
    logic        err;
    int          lat;
    int          seen;
    longint      x;
    longint      bnd [8];

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        bnd = '{0, 1, -1, 2, c_half - 1, -c_half, 12345678, -87654321};

        repeat (3) @(negedge clk);
        chk1 ("rst_in_ready",  in_ready,  1'b0);
        chk1 ("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_data",  out_data,  32'h0);
        chk1 ("rst_out_mode",  out_mode,  1'b0);
        chk1 ("rst_out_err",   out_err,   1'b0);
        rst = 1'b0;
        #1;
        chk1("idle_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Small positive value: every residue equals the value
        do_req(1'b0, 32'd5, res, err, lat);
        chk32("t1_data", res, 32'h0505_0505);
        chk32("t1_latency", lat, c_lat);
        chk1 ("t1_mode", out_mode, 1'b0);
        @(negedge clk);
        chk1 ("t1_release", out_valid, 1'b0);

        // -1 maps to M-1, whose residues are mi-1; and back again
        do_req(1'b0, 32'hFFFF_FFFF, res, err, lat);
        chk32("t2_fwd", res, 32'hFEFD_FCFA);
        @(negedge clk);
        do_req(1'b1, 32'hFEFD_FCFA, res, err, lat);
        chk32("t2_back", res, 32'hFFFF_FFFF);
        chk1 ("t2_mode", out_mode, 1'b1);
        @(negedge clk);

        do_req(1'b1, 32'h0, res, err, lat);
        chk32("t3_zero", res, 32'h0);
        @(negedge clk);

        for (int k = 0; k < 1000; k++) begin
            if (k < 8) x = bnd[k];
            else       x = (longint'($urandom) % c_m) - c_half;
            do_req(1'b0, 32'(x), fwd, err, lat);
            chk32("rt_fwd", fwd, ref_fwd(x));
            @(negedge clk);
            do_req(1'b1, fwd, res, err, lat);
            chk32("rt_back", res, 32'(x));
            @(negedge clk);
        end

        // Output stall with a competing request held at the input
        out_ready = 1'b0;
        do_req(1'b0, 32'd123456, res, err, lat);
        chk32("t4_data", res, ref_fwd(123456));
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 32'd7;
        repeat (10) begin
            @(negedge clk);
            chk32("t4_stall_data",  out_data,  ref_fwd(123456));
            chk1 ("t4_stall_valid", out_valid, 1'b1);
            chk1 ("t4_stall_ready", in_ready,  1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk1("t4_after_valid", out_valid, 1'b0);
        chk1("t4_after_ready", in_ready,  1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk1 ("t4_next_valid", out_valid, 1'b1);
        chk32("t4_next_data",  out_data,  ref_fwd(7));
        chk32("t4_next_lat",   lat,       c_lat);
        @(negedge clk);

        // Reset two cycles into CALC aborts the transaction
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 32'd99;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1 ("t5_valid", out_valid, 1'b0);
        chk32("t5_data",  out_data,  32'h0);
        chk1 ("t5_ready_in_rst", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("t5_ready_idle", in_ready, 1'b1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk32("t5_no_emit", seen, 0);
        do_req(1'b0, 32'hFFFF_FC18, res, err, lat);
        chk32("t5_fresh", res, ref_fwd(-1000));
        @(negedge clk);

        // Residue equal to its modulus: flagged only with the range check
        do_req(1'b1, 32'h0000_00FB, res, err, lat);
`ifdef RNS_RANGE_CHECK_EN
        chk1("t6_err", err, 1'b1);
`else
        chk1("t6_err", err, 1'b0);
`endif
        chk32("t6_data", res, 32'h0);
        @(negedge clk);
        chk1("t6_err_clear", out_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
